traffic_ctrl_nway: RTL and testbench

- Clocked, parametrised intersection controller replacing the purely combinational light-to-move decoder.
- Sequences NUM_WAYS approaches through GREEN -> YELLOW -> ALL_RED with programmable dwell times.
- Uses vehicle sensors to extend green and to skip idle approaches.
- Drives per-way red/yellow/green lamps and a per-way move permit; sits between the sensor front end and the lamp drivers.

---
 rtl/traffic_pkg.sv | 26 ++
 rtl/traffic_rr_pick.sv | 27 ++
 rtl/traffic_ctrl_nway.sv | 133 +++++++++++++
 tb/tb_traffic_ctrl_nway.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared state codes and lamp encoding for the N-way traffic controller
package traffic_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_GREEN   = 2'd0,
    ST_YELLOW  = 2'd1,
    ST_ALL_RED = 2'd2
  } state_t;

  // Returns {red, yellow, green} for one way; unserved ways and unknown states are red.
  function automatic logic [2:0] lamp_enc(input state_t st, input logic served);
    logic [2:0] lamp;
    lamp = 3'b100;
    if (served) begin
      case (st)
        ST_GREEN:  lamp = 3'b001;
        ST_YELLOW: lamp = 3'b010;
        default:   lamp = 3'b100;
      endcase
    end
    return lamp;
  endfunction

endpackage

// File: rtl/traffic_rr_pick.sv
// rtl/traffic_rr_pick.sv - cyclic search for the next demanding way after start, own way last
module traffic_rr_pick #(
  parameter int NUM_WAYS = 2,
  parameter int IDX_W    = $clog2(NUM_WAYS)
) (
  input  logic [NUM_WAYS-1:0] car,
  input  logic [IDX_W-1:0]    start,
  output logic [IDX_W-1:0]    next,
  output logic                any_demand
);

  // Walk offsets from far to near so the closest demanding way after start wins.
  always_comb begin
    int idx;
    idx        = 0;
    next       = start;
    any_demand = 1'b0;
    for (int k = NUM_WAYS; k >= 1; k--) begin
      idx = (int'(start) + k) % NUM_WAYS;
      if (car[idx]) begin
        next       = IDX_W'(idx);
        any_demand = 1'b1;
      end
    end
  end

endmodule

// File: rtl/traffic_ctrl_nway.sv
// rtl/traffic_ctrl_nway.sv - N-way green/yellow/all-red sequencer; EMERGENCY_PREEMPT_EN adds preemption
module traffic_ctrl_nway
  import traffic_pkg::*;
#(
  parameter int NUM_WAYS      = 2,
  parameter int GREEN_TICKS   = 8,
  parameter int YELLOW_TICKS  = 3,
  parameter int ALL_RED_TICKS = 1,
  parameter int IDX_W         = $clog2(NUM_WAYS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_WAYS-1:0] car,
  output logic [NUM_WAYS-1:0] red,
  output logic [NUM_WAYS-1:0] yellow,
  output logic [NUM_WAYS-1:0] green,
  output logic [NUM_WAYS-1:0] move,
  output logic [IDX_W-1:0]    phase,
`ifdef EMERGENCY_PREEMPT_EN
  input  logic                emerg_req,
  input  logic [IDX_W-1:0]    emerg_way,
  output logic                preempt_active,
`endif
  output logic [STATE_W-1:0]  state_o
);

  localparam int MAX_GY    = (GREEN_TICKS > YELLOW_TICKS) ? GREEN_TICKS : YELLOW_TICKS;
  localparam int MAX_TICKS = (MAX_GY > ALL_RED_TICKS) ? MAX_GY : ALL_RED_TICKS;
  localparam int TMR_W     = $clog2(MAX_TICKS) + 1;

  localparam logic [TMR_W-1:0] G_LOAD  = TMR_W'(GREEN_TICKS - 1);
  localparam logic [TMR_W-1:0] Y_LOAD  = TMR_W'(YELLOW_TICKS - 1);
  localparam logic [TMR_W-1:0] AR_LOAD = TMR_W'(ALL_RED_TICKS - 1);

  state_t                state_q;
  logic [IDX_W-1:0]      phase_q;
  logic [TMR_W-1:0]      timer_q;
  logic                  expire;
  logic [NUM_WAYS-1:0]   others;
  logic [IDX_W-1:0]      pick_way;
  logic [IDX_W-1:0]      inc_way;
  logic                  any_demand;
  logic                  preempt;
  logic [IDX_W-1:0]      emerg_tgt;

`ifdef EMERGENCY_PREEMPT_EN
  assign preempt_active = emerg_req && (int'(emerg_way) < NUM_WAYS);
  assign preempt        = preempt_active;
  assign emerg_tgt      = emerg_way;
`else
  assign preempt   = 1'b0;
  assign emerg_tgt = '0;
`endif

  assign expire  = (timer_q == '0);
  assign inc_way = (phase_q == IDX_W'(NUM_WAYS - 1)) ? '0 : phase_q + 1'b1;

  always_comb begin
    others          = car;
    others[phase_q] = 1'b0;
  end

  traffic_rr_pick #(
    .NUM_WAYS (NUM_WAYS),
    .IDX_W    (IDX_W)
  ) u_pick (
    .car        (car),
    .start      (phase_q),
    .next       (pick_way),
    .any_demand (any_demand)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_ALL_RED;
      phase_q <= IDX_W'(NUM_WAYS - 1);
      timer_q <= AR_LOAD;
    end else begin
      case (state_q)
        ST_GREEN: begin
          if (preempt && (phase_q != emerg_tgt)) begin
            state_q <= ST_YELLOW;
            timer_q <= Y_LOAD;
          end else if (preempt) begin
            timer_q <= G_LOAD;
          end else if (expire) begin
            // No competing demand keeps this way green for another full dwell.
            if (|others) begin
              state_q <= ST_YELLOW;
              timer_q <= Y_LOAD;
            end else begin
              timer_q <= G_LOAD;
            end
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        ST_YELLOW: begin
          if (expire) begin
            state_q <= ST_ALL_RED;
            timer_q <= AR_LOAD;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        ST_ALL_RED: begin
          if (expire) begin
            state_q <= ST_GREEN;
            timer_q <= G_LOAD;
            if (preempt)         phase_q <= emerg_tgt;
            else if (any_demand) phase_q <= pick_way;
            else                 phase_q <= inc_way;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        default: begin
          state_q <= ST_ALL_RED;
          timer_q <= AR_LOAD;
        end
      endcase
    end
  end

  for (genvar i = 0; i < NUM_WAYS; i++) begin : g_lamp
    assign {red[i], yellow[i], green[i]} = lamp_enc(state_q, phase_q == IDX_W'(i));
  end

  assign move    = green;
  assign phase   = phase_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_traffic_ctrl_nway.sv
// tb/tb_traffic_ctrl_nway.sv - directed table and sequence checks plus randomized lamp invariants
module tb_traffic_ctrl_nway;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // N=2, G=4, Y=2, AR=1
  logic       reset2;
  logic [1:0] car2, red2, yellow2, green2, move2, state2;
  logic       phase2;
  // N=4, G=4, Y=2, AR=1
  logic       reset4;
  logic [3:0] car4, red4, yellow4, green4, move4;
  logic [1:0] phase4, state4;
  // N=3, G=3, Y=2, AR=1
  logic       reset3;
  logic [2:0] car3, red3, yellow3, green3, move3;
  logic [1:0] phase3, state3;

`ifdef EMERGENCY_PREEMPT_EN
  logic       emerg_req2, emerg_req4, emerg_req3;
  logic       emerg_way2;
  logic [1:0] emerg_way4, emerg_way3;
  logic       preempt2, preempt4, preempt3;
`endif

  traffic_ctrl_nway #(.NUM_WAYS(2), .GREEN_TICKS(4), .YELLOW_TICKS(2), .ALL_RED_TICKS(1)) dut2 (
    .clk(clk), .reset(reset2), .car(car2), .red(red2), .yellow(yellow2), .green(green2),
    .move(move2), .phase(phase2),
`ifdef EMERGENCY_PREEMPT_EN
    .emerg_req(emerg_req2), .emerg_way(emerg_way2), .preempt_active(preempt2),
`endif
    .state_o(state2)
  );

  traffic_ctrl_nway #(.NUM_WAYS(4), .GREEN_TICKS(4), .YELLOW_TICKS(2), .ALL_RED_TICKS(1)) dut4 (
    .clk(clk), .reset(reset4), .car(car4), .red(red4), .yellow(yellow4), .green(green4),
    .move(move4), .phase(phase4),
`ifdef EMERGENCY_PREEMPT_EN
    .emerg_req(emerg_req4), .emerg_way(emerg_way4), .preempt_active(preempt4),
`endif
    .state_o(state4)
  );

  traffic_ctrl_nway #(.NUM_WAYS(3), .GREEN_TICKS(3), .YELLOW_TICKS(2), .ALL_RED_TICKS(1)) dut3 (
    .clk(clk), .reset(reset3), .car(car3), .red(red3), .yellow(yellow3), .green(green3),
    .move(move3), .phase(phase3),
`ifdef EMERGENCY_PREEMPT_EN
    .emerg_req(emerg_req3), .emerg_way(emerg_way3), .preempt_active(preempt3),
`endif
    .state_o(state3)
  );

  typedef struct {
    logic [1:0] car;
    logic [1:0] red;
    logic [1:0] yellow;
    logic [1:0] green;
    logic [1:0] st;
    logic       ph;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [1:0] c, input logic [1:0] r, input logic [1:0] y,
                     input logic [1:0] g, input logic [1:0] s, input logic p, input int n);
    vec_t v;
    v.car = c; v.red = r; v.yellow = y; v.green = g; v.st = s; v.ph = p;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  task automatic check_reset2(input string tag);
    check({tag, "_red"}, red2, 2'b11);
    check({tag, "_yellow"}, yellow2, 2'b00);
    check({tag, "_green"}, green2, 2'b00);
    check({tag, "_move"}, move2, 2'b00);
    check({tag, "_state"}, state2, 2'd2);
    check({tag, "_phase"}, phase2, 1'b1);
  endtask

  initial begin
    reset2 = 1'b1; reset4 = 1'b1; reset3 = 1'b1;
    car2 = '0; car4 = '0; car3 = '0;
`ifdef EMERGENCY_PREEMPT_EN
    emerg_req2 = 1'b0; emerg_req4 = 1'b0; emerg_req3 = 1'b0;
    emerg_way2 = 1'b0; emerg_way4 = '0; emerg_way3 = '0;
`endif

    // Cycle-by-cycle expectations after reset release: {car, red, yellow, green, state, phase}
    add(2'b00, 2'b10, 2'b00, 2'b01, 2'd0, 1'b0, 9);  // green[0], extended twice with no demand
    add(2'b10, 2'b10, 2'b00, 2'b01, 2'd0, 1'b0, 2);  // demand off-expire is ignored
    add(2'b00, 2'b10, 2'b00, 2'b01, 2'd0, 1'b0, 1);
    add(2'b10, 2'b10, 2'b01, 2'b00, 2'd1, 1'b0, 1);  // demand sampled at expire
    add(2'b00, 2'b10, 2'b01, 2'b00, 2'd1, 1'b0, 1);
    add(2'b00, 2'b11, 2'b00, 2'b00, 2'd2, 1'b0, 1);
    add(2'b10, 2'b01, 2'b00, 2'b10, 2'd0, 1'b1, 1);  // way 1 served
    add(2'b00, 2'b01, 2'b00, 2'b10, 2'd0, 1'b1, 7);
    add(2'b01, 2'b01, 2'b10, 2'b00, 2'd1, 1'b1, 1);
    add(2'b00, 2'b01, 2'b10, 2'b00, 2'd1, 1'b1, 1);
    add(2'b00, 2'b11, 2'b00, 2'b00, 2'd2, 1'b1, 1);
    add(2'b00, 2'b10, 2'b00, 2'b01, 2'd0, 1'b0, 1);  // demand withdrawn: simple increment

    tick();
    check_reset2("reset_n2");
    reset2 = 1'b0;
    foreach (tbl[i]) begin
      car2 = tbl[i].car;
      tick();
      check($sformatf("tbl%0d_red", i), red2, tbl[i].red);
      check($sformatf("tbl%0d_yellow", i), yellow2, tbl[i].yellow);
      check($sformatf("tbl%0d_green", i), green2, tbl[i].green);
      check($sformatf("tbl%0d_move", i), move2, tbl[i].green);
      check($sformatf("tbl%0d_state", i), state2, tbl[i].st);
      check($sformatf("tbl%0d_phase", i), phase2, tbl[i].ph);
    end

    // Reset landing in yellow, then in green
    car2 = 2'b10;
    for (int i = 0; i < 12 && state2 != 2'd1; i++) tick();
    check("reach_yellow", state2, 2'd1);
    car2 = 2'b00;
    reset2 = 1'b1;
    tick();
    check_reset2("reset_in_yellow");
    reset2 = 1'b0;
    tick();
    check("after_reset_green", green2, 2'b01);
    tick();
    reset2 = 1'b1;
    tick();
    check_reset2("reset_in_green");
    reset2 = 1'b0;

`ifdef EMERGENCY_PREEMPT_EN
    tick();
    check("em_start_green", green2, 2'b01);
    tick();
    emerg_way2 = 1'b1;
    emerg_req2 = 1'b1;
    #1;
    check("em_active", preempt2, 1'b1);
    tick();
    check("em_t1_yellow", yellow2, 2'b01);
    check("em_t1_state", state2, 2'd1);
    tick();
    check("em_t2_yellow", yellow2, 2'b01);
    tick();
    check("em_t3_red", red2, 2'b11);
    check("em_t3_state", state2, 2'd2);
    tick();
    check("em_t4_green", green2, 2'b10);
    check("em_t4_phase", phase2, 1'b1);
    tick();
    check("em_hold_green", green2, 2'b10);
    emerg_req2 = 1'b0;
    emerg_req3 = 1'b1;
    emerg_way3 = 2'd3;
    #1;
    check("em_bad_way_ignored", preempt3, 1'b0);
    emerg_way3 = 2'd2;
    #1;
    check("em_good_way", preempt3, 1'b1);
    emerg_req3 = 1'b0;
`endif

    // N=4: skip an idle way, then wrap from 3 to 0
    tick();
    reset4 = 1'b0;
    car4 = 4'b0010;
    tick();
    check("n4_first_phase", phase4, 2'd1);
    check("n4_first_green", green4, 4'b0010);
    car4 = 4'b0000;
    for (int i = 0; i < 3; i++) tick();
    car4 = 4'b1001;
    tick();
    check("n4_yellow", yellow4, 4'b0010);
    car4 = 4'b0000;
    tick();
    tick();
    check("n4_allred", red4, 4'b1111);
    car4 = 4'b1001;
    tick();
    check("n4_skip_phase", phase4, 2'd3);
    check("n4_skip_green", green4, 4'b1000);
    for (int i = 0; i < 7; i++) tick();
    check("n4_wrap_phase", phase4, 2'd0);
    check("n4_wrap_green", green4, 4'b0001);

    // N=3 random demand: lamp safety invariants every cycle
    reset3 = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      int lamps_bad;
      int active;
      car3 = 3'($urandom_range(0, 7));
      tick();
      lamps_bad = 0;
      active = 0;
      for (int w = 0; w < 3; w++) begin
        if ((int'(red3[w]) + int'(yellow3[w]) + int'(green3[w])) != 1) lamps_bad++;
        if (!red3[w]) active++;
      end
      check($sformatf("inv_one_lamp_c%0d", c), lamps_bad, 0);
      check($sformatf("inv_one_active_c%0d", c), (active <= 1) ? 1 : 0, 1);
      check($sformatf("inv_move_c%0d", c), move3, green3);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
